// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the MTM ALU serial datapath:
// opcodes, frame flags, CRC4 polynomial, error-flag indices and FSM states.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_e;

  localparam logic FLAG_DATA = 1'b0;
  localparam logic FLAG_CMD  = 1'b1;

  // Low-order terms of x^4+x+1; the x^4 term is the shifted-out bit.
  localparam logic [3:0] CRC4_POLY = 4'b0011;

  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLAG,
    ST_DATA,
    ST_STOP
  } state_e;

  function automatic logic op_is_valid(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mtm_alu_crc4.sv
// Serial CRC4 register (x^4+x+1, init 0), one data bit per enabled clock.
// Shared by the deserializer check and the serializer's CRC generation.
module mtm_alu_crc4
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [3:0] crc
);

  logic fb;

  assign fb = crc[3] ^ din;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      crc <= 4'b0000;
    end else if (enable) begin
      crc <= {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    end
  end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Serial input stage: decodes 11-bit frames on sin into operands B, A and a
// command, checks frame count, CRC4 and opcode, and strobes the result.
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter int DATA_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  OP,
  output logic        out_valid,
  output logic [2:0]  err_flags
);

  localparam logic [3:0] FRAMES_REQ = 4'(DATA_FRAMES);
  localparam logic [3:0] CNT_MAX    = 4'(DATA_FRAMES + 1);

  state_e      state, state_next;
  logic        flag;
  logic [2:0]  bit_cnt;
  logic [7:0]  payload;
  logic [63:0] shift_reg;
  logic [3:0]  frame_cnt;
  logic [3:0]  crc;
  logic        crc_clr, crc_en, crc_din;
  logic [2:0]  cmd_flags;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (!sin) state_next = ST_FLAG;
      ST_FLAG: state_next = ST_DATA;
      ST_DATA: if (bit_cnt == 3'd7) state_next = ST_STOP;
      ST_STOP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Command bit 0 always feeds a constant 1; bits 4..7 carry the received CRC.
  always_comb begin
    crc_en  = 1'b0;
    crc_din = sin;
    crc_clr = (state == ST_STOP) && (!sin || flag == FLAG_CMD);
    if (state == ST_DATA) begin
      if (flag == FLAG_DATA) begin
        crc_en = 1'b1;
      end else if (bit_cnt == 3'd0) begin
        crc_en  = 1'b1;
        crc_din = 1'b1;
      end else if (bit_cnt <= 3'd3) begin
        crc_en = 1'b1;
      end
    end
  end

  mtm_alu_crc4 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (crc_clr),
    .enable (crc_en),
    .din    (crc_din),
    .crc    (crc)
  );

  always_comb begin
    cmd_flags = 3'b000;
    if (frame_cnt != FRAMES_REQ)          cmd_flags[ERR_DATA] = 1'b1;
    else if (crc != payload[3:0])         cmd_flags[ERR_CRC]  = 1'b1;
    else if (!op_is_valid(payload[6:4])) cmd_flags[ERR_OP]   = 1'b1;
  end

  // NOTE: the 64-bit operand shift register is reset with the rest of the
  // state so a reset mid-sequence cannot leak stale bytes into later operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag      <= FLAG_DATA;
      bit_cnt   <= 3'd0;
      payload   <= 8'h00;
      shift_reg <= 64'h0;
      frame_cnt <= 4'd0;
      A         <= 32'h0;
      B         <= 32'h0;
      OP        <= 3'b000;
      out_valid <= 1'b0;
      err_flags <= 3'b000;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_FLAG: begin
          flag    <= sin;
          bit_cnt <= 3'd0;
        end
        ST_DATA: begin
          payload <= {payload[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
        end
        ST_STOP: begin
          if (!sin) begin
            out_valid           <= 1'b1;
            err_flags           <= 3'b000;
            err_flags[ERR_DATA] <= 1'b1;
            frame_cnt           <= 4'd0;
            shift_reg           <= 64'h0;
          end else if (flag == FLAG_CMD) begin
            A         <= shift_reg[31:0];
            B         <= shift_reg[63:32];
            OP        <= payload[6:4];
            out_valid <= 1'b1;
            err_flags <= cmd_flags;
            frame_cnt <= 4'd0;
            shift_reg <= 64'h0;
          end else if (frame_cnt < FRAMES_REQ) begin
            shift_reg <= {shift_reg[55:0], payload};
            frame_cnt <= frame_cnt + 4'd1;
          end else begin
            frame_cnt <= CNT_MAX;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Directed self-checking bench for mtm_alu_deserializer: frames are driven
// bit by bit and results compared against hand-computed values.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] A, B;
  logic [2:0]  OP;
  logic        out_valid;
  logic [2:0]  err_flags;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  mtm_alu_deserializer #(.DATA_FRAMES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .out_valid (out_valid),
    .err_flags (err_flags)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    tick();
  endtask

  task automatic send_frame(input logic flag, input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    send_bit(flag);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_data(input logic [63:0] d);
    for (int i = 0; i < 8; i++) send_frame(1'b0, d[63-8*i -: 8], 1'b1);
  endtask

  task automatic send_zero_frames(input int n);
    for (int i = 0; i < n; i++) send_frame(1'b0, 8'h00, 1'b1);
  endtask

  // Called right after the stop edge: strobe high now, low one cycle later.
  task automatic expect_strobe(input string tag, input logic [2:0] flags);
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " err_flags"}, 64'(err_flags), 64'(flags));
    send_bit(1'b1);
    check({tag, " strobe_width"}, 64'(out_valid), 64'd0);
  endtask

  // Reference CRC4 over the data bits, the constant 1 and the opcode.
  function automatic logic [7:0] make_cmd(input logic [63:0] d, input logic [2:0] op);
    logic [3:0]  c;
    logic [67:0] stream;
    logic        fb;
    c      = 4'b0000;
    stream = {d, 1'b1, op};
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ stream[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return {1'b0, op, c};
  endfunction

  initial begin
    rst = 1'b1;
    sin = 1'b1;
    tick();
    tick();
    check("reset A", 64'(A), 64'd0);
    check("reset B", 64'(B), 64'd0);
    check("reset OP", 64'(OP), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset err_flags", 64'(err_flags), 64'd0);
    rst = 1'b0;
    send_bit(1'b1);

    // Valid ADD with zero operands; no strobe after data frames alone.
    send_zero_frames(8);
    check("no strobe on data", 64'(out_valid), 64'd0);
    send_frame(1'b1, 8'h47, 1'b1);
    expect_strobe("add ok", 3'b000);
    check("add OP", 64'(OP), 64'd4);

    // Bad CRC: OP still loaded.
    send_zero_frames(8);
    send_frame(1'b1, 8'h46, 1'b1);
    expect_strobe("crc err", 3'b010);
    check("crc err OP", 64'(OP), 64'd4);

    // Unsupported opcode 010 with a correct CRC.
    send_zero_frames(8);
    send_frame(1'b1, 8'h2D, 1'b1);
    expect_strobe("op err", 3'b001);
    check("op err OP", 64'(OP), 64'd2);

    // Seven data frames, then a full valid AND.
    send_zero_frames(7);
    send_frame(1'b1, 8'h0B, 1'b1);
    expect_strobe("short seq", 3'b100);
    send_zero_frames(8);
    send_frame(1'b1, 8'h0B, 1'b1);
    expect_strobe("and ok", 3'b000);
    check("and OP", 64'(OP), 64'd0);

    // Nine data frames: counter saturates, command reports err_data.
    send_zero_frames(9);
    send_frame(1'b1, 8'h47, 1'b1);
    expect_strobe("long seq", 3'b100);

    // Byte order.
    send_data(64'h1122_3344_5566_7788);
    send_frame(1'b1, make_cmd(64'h1122_3344_5566_7788, 3'b001), 1'b1);
    expect_strobe("order", 3'b000);
    check("order B", 64'(B), 64'h1122_3344);
    check("order A", 64'(A), 64'h5566_7788);
    check("order OP", 64'(OP), 64'd1);

    // Framing error in frame 3; outputs hold, then a clean sequence.
    send_frame(1'b0, 8'hAA, 1'b1);
    send_frame(1'b0, 8'hBB, 1'b1);
    send_frame(1'b0, 8'hCC, 1'b0);
    check("framing A hold", 64'(A), 64'h5566_7788);
    check("framing B hold", 64'(B), 64'h1122_3344);
    check("framing OP hold", 64'(OP), 64'd1);
    expect_strobe("framing", 3'b100);
    send_data(64'hDEAD_BEEF_0102_0304);
    send_frame(1'b1, make_cmd(64'hDEAD_BEEF_0102_0304, 3'b101), 1'b1);
    expect_strobe("after framing", 3'b000);
    check("after framing B", 64'(B), 64'hDEAD_BEEF);
    check("after framing A", 64'(A), 64'h0102_0304);
    check("after framing OP", 64'(OP), 64'd5);

    // Reset in the middle of a data frame.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    send_bit(1'b1);
    rst = 1'b0;
    check("mid rst A", 64'(A), 64'd0);
    check("mid rst B", 64'(B), 64'd0);
    check("mid rst OP", 64'(OP), 64'd0);
    check("mid rst out_valid", 64'(out_valid), 64'd0);
    check("mid rst err_flags", 64'(err_flags), 64'd0);
    send_data(64'h0000_0007_0000_0009);
    send_frame(1'b1, make_cmd(64'h0000_0007_0000_0009, 3'b100), 1'b1);
    expect_strobe("after rst", 3'b000);
    check("after rst B", 64'(B), 64'h7);
    check("after rst A", 64'(A), 64'h9);
    check("after rst OP", 64'(OP), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
